// File: rtl/sram_a_rd_seq.sv
// sram_a_rd_seq: read-address sequencer for the SRAM_A read ports.
// A start command sweeps addresses 0..k_len for every PE row, with row r
// lagging row 0 by r cycles so the operands enter the array as a systolic
// wavefront. a_valid tracks the one-cycle registered read latency of SRAM_A.
//
// Handshake: start is a one-cycle command, accepted only while busy=0 and
// ignored otherwise (no queuing). stall freezes the sweep for that cycle:
// re drops combinationally and no progress is made. done pulses for one
// cycle when the last row's data is on the SRAM outputs.
//
// Debug: fsm_state exposes the controller state (IDLE=0, RUN=1, DRAIN=2).
module sram_a_rd_seq #(
   parameter  int ENTRYS = 16,
   parameter  int ROWS   = 8,
   localparam int AW     = $clog2(ENTRYS),
   localparam int TW     = $clog2(ENTRYS + ROWS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [AW-1:0]            k_len,
   input  logic                     stall,
   output logic [ROWS-1:0][AW-1:0]  rdaddr,
   output logic [ROWS-1:0]          re,
   output logic [ROWS-1:0]          a_valid,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [TW-1:0]             t_q, t_d;
   logic [AW-1:0]             klen_q, klen_d;
   logic                      last_run;

   // Registered per-row read pattern, computed from the next base count so
   // that it lines up with the state it belongs to.
   logic [ROWS-1:0]           act_q, act_d;
   logic [ROWS-1:0][AW-1:0]   addr_q, addr_d;
   logic [ROWS-1:0]           av_q;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   // Final RUN cycle: base count has reached klen + ROWS - 1 (compared at
   // full counter width, no truncation).
   assign last_run = (t_q == (TW'(klen_q) + TW'(ROWS - 1)));

   // Next-state, base counter and latched length.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      klen_d  = klen_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               t_d     = '0;
               klen_d  = k_len;
            end
         end
         RUN: begin
            if (!stall) begin
               if (last_run) begin
                  state_d = DRAIN;
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         DRAIN: begin
            // One cycle to cover the SRAM read latency; stall has no effect.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Per-row activity window and address for the coming cycle.
   always_comb begin
      act_d  = '0;
      addr_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         if ((state_d == RUN) && (t_d >= TW'(r)) &&
             ((t_d - TW'(r)) <= TW'(klen_d))) begin
            act_d[r]  = 1'b1;
            addr_d[r] = AW'(t_d - TW'(r));
         end
      end
   end

   // Status flags for the coming cycle.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DRAIN);
   end

   // State, counter and latched length registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         klen_q  <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         klen_q  <= klen_d;
      end
   end

   // Output pattern registers; a_valid follows the issued reads by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_q  <= '0;
         addr_q <= '0;
         av_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         act_q  <= act_d;
         addr_q <= addr_d;
         av_q   <= re;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // Read enables are the registered pattern gated by the live stall.
   assign re        = act_q & {ROWS{~stall}};
   assign rdaddr    = addr_q;
   assign a_valid   = av_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_sram_a_rd_seq.sv
// Bench for sram_a_rd_seq: each scenario builds an expected per-cycle table
// from the sweep rules, plays stimulus, then compares cycle by cycle.
module tb_sram_a_rd_seq;
   localparam int ENTRYS = 16;
   localparam int ROWS   = 8;
   localparam int AW     = 4;
   localparam int N      = 64;

   logic                    clk = 1'b0;
   logic                    rst, start, stall;
   logic [AW-1:0]           k_len;
   logic [ROWS-1:0][AW-1:0] rdaddr;
   logic [ROWS-1:0]         re, a_valid;
   logic                    busy, done;
   logic [1:0]              fsm_state;

   int n_checks = 0;
   int n_pass   = 0;

   // observed and expected per-cycle tables
   logic [ROWS-1:0]         obs_re[N], exp_re[N];
   logic [ROWS-1:0][AW-1:0] obs_addr[N], exp_addr[N];
   logic [ROWS-1:0]         obs_av[N], exp_av[N];
   logic                    obs_busy[N], exp_busy[N];
   logic                    obs_done[N], exp_done[N];
   logic [1:0]              obs_state[N];

   always #5 clk = ~clk;

   sram_a_rd_seq #(.ENTRYS(ENTRYS), .ROWS(ROWS)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall),
      .rdaddr(rdaddr), .re(re), .a_valid(a_valid), .busy(busy),
      .done(done), .fsm_state(fsm_state)
   );

   task automatic clear_from(input int c0);
      for (int c = (c0 < 0 ? 0 : c0); c < N; c++) begin
         exp_re[c] = '0; exp_addr[c] = '0; exp_av[c] = '0;
         exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
      end
   endtask

   // Reference: the j-th non-stalled RUN cycle of a sweep serves address
   // j-r on row r (when 0 <= j-r <= k); data is valid one cycle later; done
   // follows the last issue cycle; a start is honoured only once idle.
   task automatic build_model(input int n, input int k0, input int s2, input int k1,
                              input logic [N-1:0] smask, input int rst_c);
      int idle_from, kk, c, j, s;
      clear_from(0);
      idle_from = 0;
      for (int w = 0; w < 2; w++) begin
         s  = (w == 0) ? 0 : s2;
         kk = (w == 0) ? k0 : k1;
         if (w == 1 && rst_c >= 0 && rst_c < s) begin
            clear_from(rst_c + 1);
            idle_from = rst_c + 1;
         end
         if (s < 0 || s < idle_from || s >= n) continue;
         c = s + 1;
         j = 0;
         while (j < kk + ROWS && c < N) begin
            exp_busy[c] = 1'b1;
            if (!smask[c]) begin
               for (int r = 0; r < ROWS; r++) begin
                  if (j - r >= 0 && j - r <= kk) begin
                     exp_re[c][r]   = 1'b1;
                     exp_addr[c][r] = AW'(j - r);
                     if (c + 1 < N) exp_av[c+1][r] = 1'b1;
                  end
               end
               j++;
            end
            c++;
         end
         if (c < N) begin
            exp_busy[c] = 1'b1;
            exp_done[c] = 1'b1;
         end
         idle_from = c + 1;
      end
      if (rst_c >= 0 && !(s2 > rst_c)) clear_from(rst_c + 1);
   endtask

   // Drive one scenario: cycle 0 carries the first start; optional second
   // start at s2 and optional reset pulse at rst_c. Samples on the falling edge.
   task automatic play(input int n, input int k0, input int s2, input int k1,
                       input logic [N-1:0] smask, input int rst_c);
      rst = 1'b1; start = 1'b0; stall = 1'b0; k_len = '0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < n; c++) begin
         start = (c == 0) || (c == s2);
         if (c == 0)       k_len = AW'(k0);
         else if (c == s2) k_len = AW'(k1);
         else              k_len = AW'($urandom_range(0, ENTRYS - 1));
         stall = smask[c];
         rst   = (c == rst_c);
         @(negedge clk);
         obs_re[c] = re; obs_addr[c] = rdaddr; obs_av[c] = a_valid;
         obs_busy[c] = busy; obs_done[c] = done; obs_state[c] = fsm_state;
         @(posedge clk); #1;
      end
      start = 1'b0; stall = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; stall = 1'b0; k_len = 4'd5;
      @(posedge clk); @(posedge clk); @(negedge clk);
      n_checks++;
      if ({re, rdaddr, a_valid, busy, done} !== '0)
         $display("FAIL reset outputs got re=%b av=%b busy=%b done=%b exp all 0", re, a_valid, busy, done);
      else n_pass++;
      n_checks++;
      if (fsm_state !== 2'd0) $display("FAIL reset state got=%0d exp=0", fsm_state);
      else n_pass++;
      start = 1'b0;
   endtask

   task automatic test_basic();
      int n = 20;
      build_model(n, 3, -1, 0, '0, -1);
      play(n, 3, -1, 0, '0, -1);
      for (int c = 0; c < n; c++) begin
         logic [ROWS-1:0][AW-1:0] m;
         m = obs_addr[c];
         for (int r = 0; r < ROWS; r++) if (!exp_re[c][r]) m[r] = '0;
         n_checks++; if (obs_re[c] !== exp_re[c]) $display("FAIL basic re c=%0d got=%b exp=%b", c, obs_re[c], exp_re[c]); else n_pass++;
         n_checks++; if (m !== exp_addr[c]) $display("FAIL basic rdaddr c=%0d got=%h exp=%h", c, m, exp_addr[c]); else n_pass++;
         n_checks++; if (obs_av[c] !== exp_av[c]) $display("FAIL basic a_valid c=%0d got=%b exp=%b", c, obs_av[c], exp_av[c]); else n_pass++;
         n_checks++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL basic busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); else n_pass++;
         n_checks++; if (obs_done[c] !== exp_done[c]) $display("FAIL basic done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); else n_pass++;
      end
      n_checks++; if (obs_done[12] !== 1'b1) $display("FAIL basic done_at_12 got=%b exp=1", obs_done[12]); else n_pass++;
   endtask

   task automatic test_k_bounds();
      int n = 30;
      int ks[2] = '{0, 15};
      for (int i = 0; i < 2; i++) begin
         build_model(n, ks[i], -1, 0, '0, -1);
         play(n, ks[i], -1, 0, '0, -1);
         for (int c = 0; c < n; c++) begin
            logic [ROWS-1:0][AW-1:0] m;
            m = obs_addr[c];
            for (int r = 0; r < ROWS; r++) if (!exp_re[c][r]) m[r] = '0;
            n_checks++; if (obs_re[c] !== exp_re[c]) $display("FAIL kbound k=%0d re c=%0d got=%b exp=%b", ks[i], c, obs_re[c], exp_re[c]); else n_pass++;
            n_checks++; if (m !== exp_addr[c]) $display("FAIL kbound k=%0d rdaddr c=%0d got=%h exp=%h", ks[i], c, m, exp_addr[c]); else n_pass++;
            n_checks++; if (obs_av[c] !== exp_av[c]) $display("FAIL kbound k=%0d a_valid c=%0d got=%b exp=%b", ks[i], c, obs_av[c], exp_av[c]); else n_pass++;
            n_checks++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL kbound k=%0d busy c=%0d got=%b exp=%b", ks[i], c, obs_busy[c], exp_busy[c]); else n_pass++;
            n_checks++; if (obs_done[c] !== exp_done[c]) $display("FAIL kbound k=%0d done c=%0d got=%b exp=%b", ks[i], c, obs_done[c], exp_done[c]); else n_pass++;
         end
      end
   endtask

   task automatic test_stall();
      int n = 20;
      logic [N-1:0] sm = '0;
      sm[3] = 1'b1; sm[4] = 1'b1;
      build_model(n, 3, -1, 0, sm, -1);
      play(n, 3, -1, 0, sm, -1);
      for (int c = 0; c < n; c++) begin
         logic [ROWS-1:0][AW-1:0] m;
         m = obs_addr[c];
         for (int r = 0; r < ROWS; r++) if (!exp_re[c][r]) m[r] = '0;
         n_checks++; if (obs_re[c] !== exp_re[c]) $display("FAIL stall re c=%0d got=%b exp=%b", c, obs_re[c], exp_re[c]); else n_pass++;
         n_checks++; if (m !== exp_addr[c]) $display("FAIL stall rdaddr c=%0d got=%h exp=%h", c, m, exp_addr[c]); else n_pass++;
         n_checks++; if (obs_av[c] !== exp_av[c]) $display("FAIL stall a_valid c=%0d got=%b exp=%b", c, obs_av[c], exp_av[c]); else n_pass++;
         n_checks++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL stall busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); else n_pass++;
         n_checks++; if (obs_done[c] !== exp_done[c]) $display("FAIL stall done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); else n_pass++;
      end
      n_checks++; if (obs_addr[5][0] !== 4'd2) $display("FAIL stall resume_addr got=%0d exp=2", obs_addr[5][0]); else n_pass++;
   endtask

   task automatic test_random_stall();
      int n = N;
      int k;
      logic [N-1:0] sm;
      for (int it = 0; it < 4; it++) begin
         k  = int'($urandom_range(0, ENTRYS - 1));
         sm = '0;
         for (int c = 1; c < 36; c++) sm[c] = ($urandom_range(0, 3) == 0);
         build_model(n, k, -1, 0, sm, -1);
         play(n, k, -1, 0, sm, -1);
         for (int c = 0; c < n; c++) begin
            logic [ROWS-1:0][AW-1:0] m;
            m = obs_addr[c];
            for (int r = 0; r < ROWS; r++) if (!exp_re[c][r]) m[r] = '0;
            n_checks++; if (obs_re[c] !== exp_re[c]) $display("FAIL rstall k=%0d re c=%0d got=%b exp=%b", k, c, obs_re[c], exp_re[c]); else n_pass++;
            n_checks++; if (m !== exp_addr[c]) $display("FAIL rstall k=%0d rdaddr c=%0d got=%h exp=%h", k, c, m, exp_addr[c]); else n_pass++;
            n_checks++; if (obs_av[c] !== exp_av[c]) $display("FAIL rstall k=%0d a_valid c=%0d got=%b exp=%b", k, c, obs_av[c], exp_av[c]); else n_pass++;
            n_checks++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL rstall k=%0d busy c=%0d got=%b exp=%b", k, c, obs_busy[c], exp_busy[c]); else n_pass++;
            n_checks++; if (obs_done[c] !== exp_done[c]) $display("FAIL rstall k=%0d done c=%0d got=%b exp=%b", k, c, obs_done[c], exp_done[c]); else n_pass++;
         end
      end
   endtask

   task automatic test_start_busy();
      int n = 20;
      int k1 = int'($urandom_range(4, ENTRYS - 1));
      build_model(n, 3, 5, k1, '0, -1);
      play(n, 3, 5, k1, '0, -1);
      for (int c = 0; c < n; c++) begin
         n_checks++; if (obs_re[c] !== exp_re[c]) $display("FAIL start_busy re c=%0d got=%b exp=%b", c, obs_re[c], exp_re[c]); else n_pass++;
         n_checks++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL start_busy busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); else n_pass++;
         n_checks++; if (obs_done[c] !== exp_done[c]) $display("FAIL start_busy done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_run();
      int n = 30;
      int k1 = int'($urandom_range(0, ENTRYS - 1));
      build_model(n, 3, 8, k1, '0, 6);
      play(n, 3, 8, k1, '0, 6);
      n_checks++; if (obs_state[7] !== 2'd0) $display("FAIL reset_mid state c=7 got=%0d exp=0", obs_state[7]); else n_pass++;
      n_checks++; if (obs_addr[7] !== '0) $display("FAIL reset_mid rdaddr c=7 got=%h exp=0", obs_addr[7]); else n_pass++;
      for (int c = 0; c < n; c++) begin
         n_checks++; if (obs_re[c] !== exp_re[c]) $display("FAIL reset_mid re c=%0d got=%b exp=%b", c, obs_re[c], exp_re[c]); else n_pass++;
         n_checks++; if (obs_av[c] !== exp_av[c]) $display("FAIL reset_mid a_valid c=%0d got=%b exp=%b", c, obs_av[c], exp_av[c]); else n_pass++;
         n_checks++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL reset_mid busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); else n_pass++;
         n_checks++; if (obs_done[c] !== exp_done[c]) $display("FAIL reset_mid done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int n = 30;
      build_model(n, 3, 13, 3, '0, -1);
      play(n, 3, 13, 3, '0, -1);
      for (int c = 0; c < n; c++) begin
         logic [ROWS-1:0][AW-1:0] m;
         m = obs_addr[c];
         for (int r = 0; r < ROWS; r++) if (!exp_re[c][r]) m[r] = '0;
         n_checks++; if (obs_re[c] !== exp_re[c]) $display("FAIL b2b re c=%0d got=%b exp=%b", c, obs_re[c], exp_re[c]); else n_pass++;
         n_checks++; if (m !== exp_addr[c]) $display("FAIL b2b rdaddr c=%0d got=%h exp=%h", c, m, exp_addr[c]); else n_pass++;
         n_checks++; if (obs_av[c] !== exp_av[c]) $display("FAIL b2b a_valid c=%0d got=%b exp=%b", c, obs_av[c], exp_av[c]); else n_pass++;
         n_checks++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL b2b busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); else n_pass++;
         n_checks++; if (obs_done[c] !== exp_done[c]) $display("FAIL b2b done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); else n_pass++;
      end
      n_checks++; if (obs_done[25] !== 1'b1) $display("FAIL b2b second_done got=%b exp=1", obs_done[25]); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; k_len = '0;
      test_reset();
      test_basic();
      test_k_bounds();
      test_stall();
      test_random_stall();
      test_start_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
